usb_data_buffer: RTL

// - 64-byte shared FIFO between the AHB-Lite slave interface and the USB RX/TX packet engines.
// - AHB side: writes TX payload (store_tx_data/tx_data) and reads RX payload (get_rx_data/rx_data).
// - USB side: the RX decoder pushes payload bytes; the TX encoder pops payload bytes.
// - Reports occupancy (0..DEPTH) and supports a synchronous flush (clear) driven by the AHB flush register.

---
 rtl/usb_data_buffer.sv | 111 +++++++++++
 1 files changed

// File: rtl/usb_data_buffer.sv
// 64-byte shared byte FIFO between AHB slave and USB RX/TX packet engines.
// Optional sticky error flags: define USB_DATA_BUFFER_ERR_FLAGS_EN.
module usb_data_buffer #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              store_tx_data,
    input  logic [7:0]        tx_data,
    input  logic              get_rx_data,
    output logic [7:0]        rx_data,
    input  logic              store_rx_packet_data,
    input  logic [7:0]        rx_packet_data,
    input  logic              get_tx_packet_data,
    output logic [7:0]        tx_packet_data,
    output logic [ADDR_W:0]   buffer_occupancy
`ifdef USB_DATA_BUFFER_ERR_FLAGS_EN
    ,
    output logic              overflow_err,
    output logic              underflow_err
`endif
);

    localparam logic [ADDR_W:0] LP_FULL = DEPTH[ADDR_W:0];

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_occ;
    logic [7:0]        r_rx_data;
    logic [7:0]        r_tx_pkt;

    logic       w_push_req;
    logic       w_pop_req;
    logic [7:0] w_push_byte;
    logic       w_empty;
    logic       w_full;
    logic       w_do_pop;
    logic       w_do_push;

    assign w_push_req  = store_tx_data | store_rx_packet_data;
    assign w_pop_req   = get_tx_packet_data | get_rx_data;
    assign w_push_byte = store_tx_data ? tx_data : rx_packet_data;
    assign w_empty     = (r_occ == '0);
    assign w_full      = (r_occ == LP_FULL);
    // On full, a concurrent pop frees the slot the push writes into.
    assign w_do_pop    = ~clear & w_pop_req & ~w_empty;
    assign w_do_push   = ~clear & w_push_req & (~w_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= w_push_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
            r_rx_data <= '0;
            r_tx_pkt  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                if (get_tx_packet_data) r_tx_pkt <= r_mem[r_rd_ptr];
                else                    r_rx_data <= r_mem[r_rd_ptr];
            end
            if (w_do_push && !w_do_pop)      r_occ <= r_occ + 1'b1;
            else if (w_do_pop && !w_do_push) r_occ <= r_occ - 1'b1;
        end
    end

    assign rx_data          = r_rx_data;
    assign tx_packet_data   = r_tx_pkt;
    assign buffer_occupancy = r_occ;

`ifdef USB_DATA_BUFFER_ERR_FLAGS_EN
    logic r_ovf;
    logic r_unf;
    logic w_push_drop;
    logic w_pop_drop;

    assign w_push_drop = (store_tx_data & store_rx_packet_data)
                       | (w_push_req & ~w_do_push);
    assign w_pop_drop  = (get_tx_packet_data & get_rx_data)
                       | (w_pop_req & ~w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (clear) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_push_drop) r_ovf <= 1'b1;
            if (w_pop_drop)  r_unf <= 1'b1;
        end
    end

    assign overflow_err  = r_ovf;
    assign underflow_err = r_unf;
`endif

endmodule
